// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, tap table and period helper for lfsr_prng
//
// Contents:
//   LFSR_MIN_WIDTH / LFSR_MAX_WIDTH  legal state width range (3..32)
//   lfsr_op_e                        per-cycle register action, decoded by priority
//   lfsr_taps(w)                     maximal-length XNOR tap mask, bit i = stage i+1
//   lfsr_period(w)                   sequence length 2^w - 1
package lfsr_pkg;

  localparam int LFSR_MIN_WIDTH = 3;
  localparam int LFSR_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    LFSR_OP_HOLD = 2'd0,
    LFSR_OP_STEP = 2'd1,
    LFSR_OP_LOAD = 2'd2
  } lfsr_op_e;

  // Maximal-length tap sets for a shift-left Fibonacci register with
  // XNOR feedback. Unsupported widths return zero.
  function automatic logic [31:0] lfsr_taps(input int w);
    logic [31:0] t;
    case (w)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = 32'h0000_0000;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] lfsr_period(input int w);
    logic [31:0] p;
    if (w < 1 || w > LFSR_MAX_WIDTH) begin
      p = 32'h0;
    end else begin
      p = 32'hFFFF_FFFF >> (LFSR_MAX_WIDTH - w);
    end
    return p;
  endfunction

endpackage

// File: rtl/lfsr_period_checker.sv
// rtl/lfsr_period_checker.sv - step counter that flags an LFSR whose period is not 2^WIDTH-1
//
// Built only when LFSR_PERIOD_CHECK_EN is defined.
// Ports:
//   clk    in  1  clock, rising edge
//   rst_n  in  1  asynchronous active-low reset
//   clr    in  1  restart counting (seed load); also clears err
//   step   in  1  the LFSR advances this cycle
//   hit    in  1  the state being stepped into equals the start value
//   err    out 1  sticky: a wrap arrived at the wrong step count
`ifdef LFSR_PERIOD_CHECK_EN
module lfsr_period_checker
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic hit,
  output logic err
);

  localparam logic [31:0]      PERIOD = lfsr_period(WIDTH);
  localparam logic [WIDTH-1:0] LAST   = WIDTH'(PERIOD - 32'd1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic             at_last;
  logic             err_q;

  // count_q = steps taken since the start value; the P-th step is taken
  // while count_q == P-1, so a correct wrap and at_last coincide.
  assign at_last = (count_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else if (step) begin
      // Wrapping at P-1 keeps the counter off the all-ones value.
      if (hit || at_last) begin
        count_q <= '0;
      end else begin
        count_q <= count_q + ONE;
      end
      if (hit != at_last) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule
`endif

// File: rtl/lfsr_prng.sv
// rtl/lfsr_prng.sv - parametrised maximal-length XNOR Fibonacci LFSR with seed load and wrap detect
//
// Optional feature macro: LFSR_PERIOD_CHECK_EN (adds step counter and period checker).
// Parameters:
//   WIDTH      state width, 3..32
//   TAPS       tap mask (bit i = stage i+1); zero selects lfsr_taps(WIDTH)
//   RESET_VAL  state after reset; must not be all-ones
// Ports:
//   clk         in   1      clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   enb         in   1      advance one step per cycle while high
//   load        in   1      synchronous seed load (wins over enb)
//   seed        in   WIDTH  value captured on load
//   out         out  WIDTH  current LFSR state
//   wrap        out  1      pulse when out returns to the start value
//   seed_fixed  out  1      pulse when an all-ones seed was replaced by zero
//   period_err  out  1      sticky period mismatch (0 without the checker)
module lfsr_prng
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TAPS      = '0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] out,
  output logic             wrap,
  output logic             seed_fixed,
  output logic             period_err
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [31:0]      TAPS_TBL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS_EFF = (TAPS == '0) ? TAPS_TBL[WIDTH-1:0] : TAPS;

  generate
    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
      $error("lfsr_prng: WIDTH %0d outside 3..32", WIDTH);
    end
    if (RESET_VAL == ALL_ONES) begin : g_bad_reset
      $error("lfsr_prng: RESET_VAL all-ones is the lockup state");
    end
  endgenerate

  lfsr_op_e         op;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] out_next;
  logic [WIDTH-1:0] seed_eff;
  logic             fb;
  logic             seed_ones;
  logic             hit;
  logic             wrap_q;
  logic             seed_fixed_q;

  always_comb begin
    op = LFSR_OP_HOLD;
    if (load) begin
      op = LFSR_OP_LOAD;
    end else if (enb) begin
      op = LFSR_OP_STEP;
    end
  end

  // XNOR feedback: all-zeros steps to ...01, all-ones would stick.
  assign fb       = ~^(out_q & TAPS_EFF);
  assign out_next = {out_q[WIDTH-2:0], fb};

  assign seed_ones = &seed;
  assign seed_eff  = seed_ones ? '0 : seed;

  // Compare against the value being stepped into so wrap lands on the
  // same edge as the state that triggers it.
  assign hit = (out_next == start_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= RESET_VAL;
      start_q      <= RESET_VAL;
      wrap_q       <= 1'b0;
      seed_fixed_q <= 1'b0;
    end else begin
      wrap_q       <= 1'b0;
      seed_fixed_q <= 1'b0;
      case (op)
        LFSR_OP_LOAD: begin
          out_q        <= seed_eff;
          start_q      <= seed_eff;
          seed_fixed_q <= seed_ones;
        end
        LFSR_OP_STEP: begin
          out_q  <= out_next;
          wrap_q <= hit;
        end
        default: begin
        end
      endcase
    end
  end

  assign out        = out_q;
  assign wrap       = wrap_q;
  assign seed_fixed = seed_fixed_q;

`ifdef LFSR_PERIOD_CHECK_EN
  lfsr_period_checker #(
    .WIDTH (WIDTH)
  ) u_period_checker (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (op == LFSR_OP_LOAD),
    .step  (op == LFSR_OP_STEP),
    .hit   (hit),
    .err   (period_err)
  );
`else
  assign period_err = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_prng.sv
// tb/tb_lfsr_prng.sv - directed self-checking bench for lfsr_prng
module tb_lfsr_prng;

`ifdef LFSR_PERIOD_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       enb;
  logic       load;
  logic [3:0] seed;
  logic [3:0] out;
  logic       wrap;
  logic       seed_fixed;
  logic       period_err;

  logic       enb_nm;
  logic       load_nm;
  logic [3:0] seed_nm;
  logic [3:0] out_nm;
  logic       wrap_nm;
  logic       sf_nm;
  logic       perr_nm;

  logic       enb8;
  logic       load8;
  logic [7:0] seed8;
  logic [7:0] out8;
  logic       wrap8;
  logic       sf8;
  logic       perr8;

  int checks;
  int errors;

  lfsr_prng #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb),
    .load       (load),
    .seed       (seed),
    .out        (out),
    .wrap       (wrap),
    .seed_fixed (seed_fixed),
    .period_err (period_err)
  );

  lfsr_prng #(.WIDTH(4), .TAPS(4'b1010)) dut_nm (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb_nm),
    .load       (load_nm),
    .seed       (seed_nm),
    .out        (out_nm),
    .wrap       (wrap_nm),
    .seed_fixed (sf_nm),
    .period_err (perr_nm)
  );

  lfsr_prng #(.WIDTH(8)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb8),
    .load       (load8),
    .seed       (seed8),
    .out        (out8),
    .wrap       (wrap8),
    .seed_fixed (sf8),
    .period_err (perr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-stepped sequence for taps 4'b1100 starting from 0000.
  logic [3:0] exp_seq [15] = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB, 4'h6, 4'hC,
                               4'h9, 4'h2, 4'h5, 4'hA, 4'h4, 4'h8, 4'h0};
  // Taps 4'b1010 from 0000: period 6.
  logic [3:0] exp_nm [6] = '{4'h1, 4'h3, 4'h6, 4'hC, 4'h8, 4'h0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  logic [15:0] seen;
  int main_wraps, main_first, nm_wraps, nm_first, w8_wraps, w8_first;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    enb = 1'b0;   load = 1'b0;   seed = 4'h0;
    enb_nm = 1'b0; load_nm = 1'b0; seed_nm = 4'h0;
    enb8 = 1'b0;  load8 = 1'b0;  seed8 = 8'h0;
    tick();
    tick();
    check("rst_out", out, 4'h0);
    check("rst_wrap", wrap, 1'b0);
    check("rst_sf", seed_fixed, 1'b0);
    check("rst_perr", period_err, 1'b0);
    rst_n = 1'b1;

    // 1: first four steps
    enb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_out", out, exp_seq[i]);
      check("t1_wrap", wrap, 1'b0);
    end
    enb = 1'b0;

    // 2: two full periods from reset
    do_reset();
    enb = 1'b1;
    seen = '0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      check("t2_out", out, exp_seq[(c - 1) % 15]);
      check("t2_wrap", wrap, (c % 15) == 0);
      if (c <= 15) seen[out] = 1'b1;
    end
    check("t2_cover", seen, 16'h7FFF);

    // 3: hold, then load with enb low
    enb = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t3_hold_out", out, 4'h0);
      check("t3_hold_wrap", wrap, 1'b0);
      check("t3_hold_sf", seed_fixed, 1'b0);
    end
    load = 1'b1;
    seed = 4'hA;
    tick();
    load = 1'b0;
    check("t3_load_out", out, 4'hA);
    check("t3_load_wrap", wrap, 1'b0);
    check("t3_load_sf", seed_fixed, 1'b0);
    enb = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t3_out", out, exp_seq[(11 + k) % 15]);
      check("t3_wrap", wrap, k == 15);
    end

    // 4: all-ones seed replaced by zero
    enb = 1'b0;
    load = 1'b1;
    seed = 4'hF;
    tick();
    load = 1'b0;
    check("t4_out", out, 4'h0);
    check("t4_sf", seed_fixed, 1'b1);
    check("t4_wrap", wrap, 1'b0);
    enb = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("t4_step_out", out, exp_seq[k - 1]);
      check("t4_step_wrap", wrap, k == 15);
      check("t4_step_sf", seed_fixed, 1'b0);
    end

    // load in the cycle wrap would fire
    for (int k = 1; k <= 14; k++) tick();
    check("lw_pre", out, 4'h8);
    load = 1'b1;
    seed = 4'h5;
    tick();
    load = 1'b0;
    check("lw_out", out, 4'h5);
    check("lw_wrap", wrap, 1'b0);
    tick();
    check("lw_next", out, 4'hA);

    // 5: asynchronous reset mid-cycle
    do_reset();
    enb = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    check("t5_pre", out, 4'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_out", out, 4'h0);
    check("t5_async_wrap", wrap, 1'b0);
    tick();
    check("t5_held", out, 4'h0);
    rst_n = 1'b1;
    tick();
    check("t5_resume", out, 4'h1);
    enb = 1'b0;

    // 6: long run of all three instances
    do_reset();
    enb = 1'b1;
    enb_nm = 1'b1;
    enb8 = 1'b1;
    main_wraps = 0; main_first = 0;
    nm_wraps = 0;   nm_first = 0;
    w8_wraps = 0;   w8_first = 0;
    for (int c = 1; c <= 260; c++) begin
      tick();
      if (c <= 6) check("nm_out", out_nm, exp_nm[c - 1]);
      if (c == 6) check("nm_perr_set", perr_nm, CHK_EN);
      if (wrap) begin
        main_wraps++;
        if (main_first == 0) main_first = c;
      end
      if (wrap_nm) begin
        nm_wraps++;
        if (nm_first == 0) nm_first = c;
      end
      if (wrap8) begin
        w8_wraps++;
        if (w8_first == 0) w8_first = c;
      end
    end
    enb = 1'b0;
    enb_nm = 1'b0;
    enb8 = 1'b0;
    check("main_first", main_first, 15);
    check("main_wraps", main_wraps, 17);
    check("nm_first", nm_first, 6);
    check("nm_wraps", nm_wraps, 43);
    check("w8_first", w8_first, 255);
    check("w8_wraps", w8_wraps, 1);
    check("main_perr", period_err, 1'b0);
    check("w8_perr", perr8, 1'b0);
    check("nm_perr_sticky", perr_nm, CHK_EN);
    load_nm = 1'b1;
    seed_nm = 4'h0;
    tick();
    load_nm = 1'b0;
    check("nm_perr_clr", perr_nm, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
